// File: rtl/n64_rgb2ypbpr.sv
// N64 RGB to BT.601 YPbPr / RGB pass-through stage, 3-deep pipeline gated by the pixel strobe.
// Composite sync travels through a matching strobe-gated delay line to stay aligned with video.
module n64_rgb2ypbpr #(
   parameter int unsigned LAT       = 3,
   parameter int unsigned PBPR_OFFS = 64
) (
   input  logic       VCLK_i,
   input  logic       nRST_i,
   input  logic       nDSYNC_i,
   input  logic [6:0] R_i,
   input  logic [6:0] G_i,
   input  logic [6:0] B_i,
   input  logic       nCSYNC_i,
   input  logic       nYPbPr_i,
   output logic [6:0] V1_o,
   output logic [6:0] V2_o,
   output logic [6:0] V3_o,
   output logic       nCSYNC_o
);

   typedef logic signed [18:0] prod_t;

   localparam logic signed [9:0] OFFS = 10'(PBPR_OFFS);

   function automatic prod_t f_mul(input logic [6:0] c, input prod_t k);
      return $signed({12'b0, c}) * k;
   endfunction

   // Row sum with round-to-nearest, then scale back by 1/1024.
   function automatic logic signed [8:0] f_rnd(input prod_t a, input prod_t b, input prod_t c);
      prod_t s;
      s = a + b + c + 19'sd512;
      return 9'(s >>> 10);
   endfunction

   function automatic logic [6:0] f_clamp(input logic signed [9:0] v);
      if (v < 10'sd0) begin
         return 7'd0;
      end else if (v > 10'sd127) begin
         return 7'd127;
      end else begin
         return v[6:0];
      end
   endfunction

   // Stage 1: products, raw colour, mode
   prod_t r_yr, r_yg, r_yb, r_br, r_bg, r_bb, r_rr, r_rg, r_rb;
   logic [6:0] r_r1, r_g1, r_b1;
   logic       r_mode1;
   // Stage 2: rounded components
   logic signed [8:0] r_y2, r_pb2, r_pr2;
   logic [6:0] r_r2, r_g2, r_b2;
   logic       r_mode2;
   // Stage 3: output registers
   logic [6:0] r_v1, r_v2, r_v3;
   logic [LAT-1:0] r_sync;

   logic [6:0] w_y, w_pb, w_pr;

   always_comb begin
      w_y  = f_clamp({r_y2[8], r_y2});
      w_pb = f_clamp({r_pb2[8], r_pb2} + OFFS);
      w_pr = f_clamp({r_pr2[8], r_pr2} + OFFS);
   end

   always_ff @(posedge VCLK_i) begin
      if (!nRST_i) begin
         r_yr    <= '0;
         r_yg    <= '0;
         r_yb    <= '0;
         r_br    <= '0;
         r_bg    <= '0;
         r_bb    <= '0;
         r_rr    <= '0;
         r_rg    <= '0;
         r_rb    <= '0;
         r_r1    <= '0;
         r_g1    <= '0;
         r_b1    <= '0;
         r_mode1 <= 1'b1;
         r_y2    <= '0;
         r_pb2   <= '0;
         r_pr2   <= '0;
         r_r2    <= '0;
         r_g2    <= '0;
         r_b2    <= '0;
         r_mode2 <= 1'b1;
         r_v1    <= '0;
         r_v2    <= '0;
         r_v3    <= '0;
         r_sync  <= '1;
      end else if (!nDSYNC_i) begin
         r_yr    <= f_mul(R_i, 19'sd306);
         r_yg    <= f_mul(G_i, 19'sd601);
         r_yb    <= f_mul(B_i, 19'sd117);
         r_br    <= f_mul(R_i, -19'sd173);
         r_bg    <= f_mul(G_i, -19'sd339);
         r_bb    <= f_mul(B_i, 19'sd512);
         r_rr    <= f_mul(R_i, 19'sd512);
         r_rg    <= f_mul(G_i, -19'sd429);
         r_rb    <= f_mul(B_i, -19'sd83);
         r_r1    <= R_i;
         r_g1    <= G_i;
         r_b1    <= B_i;
         r_mode1 <= nYPbPr_i;

         r_y2    <= f_rnd(r_yr, r_yg, r_yb);
         r_pb2   <= f_rnd(r_br, r_bg, r_bb);
         r_pr2   <= f_rnd(r_rr, r_rg, r_rb);
         r_r2    <= r_r1;
         r_g2    <= r_g1;
         r_b2    <= r_b1;
         r_mode2 <= r_mode1;

         if (r_mode2) begin
            r_v1 <= r_r2;
            r_v2 <= r_g2;
            r_v3 <= r_b2;
         end else begin
            r_v1 <= w_pr;
            r_v2 <= w_y;
            r_v3 <= w_pb;
         end
         r_sync  <= {r_sync[LAT-2:0], nCSYNC_i};
      end
   end

   assign V1_o     = r_v1;
   assign V2_o     = r_v2;
   assign V3_o     = r_v3;
   assign nCSYNC_o = r_sync[LAT-1];

endmodule

// File: tb/tb_n64_rgb2ypbpr.sv
// Directed bench for n64_rgb2ypbpr: colour vectors, clamping, strobe gating, mode toggle, reset.
module tb_n64_rgb2ypbpr;

   logic       clk = 1'b0;
   logic       rst_n, dsync_n, csync_n, ypbpr_n;
   logic [6:0] r, g, b;
   logic [6:0] v1, v2, v3;
   logic       csync_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   n64_rgb2ypbpr #(
      .LAT       (3),
      .PBPR_OFFS (64)
   ) dut (
      .VCLK_i   (clk),
      .nRST_i   (rst_n),
      .nDSYNC_i (dsync_n),
      .R_i      (r),
      .G_i      (g),
      .B_i      (b),
      .nCSYNC_i (csync_n),
      .nYPbPr_i (ypbpr_n),
      .V1_o     (v1),
      .V2_o     (v2),
      .V3_o     (v3),
      .nCSYNC_o (csync_o)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_px(input string tag, input int e1, input int e2, input int e3,
                           input int es);
      check({tag, "_v1"}, int'(v1), e1);
      check({tag, "_v2"}, int'(v2), e2);
      check({tag, "_v3"}, int'(v3), e3);
      check({tag, "_sync"}, int'(csync_o), es);
   endtask

   // Inputs change on negedge, DUT samples on the next posedge, caller checks on the next negedge.
   task automatic drive(input logic [6:0] rr, input logic [6:0] gg, input logic [6:0] bb,
                        input logic s, input logic m, input logic ds);
      r       = rr;
      g       = gg;
      b       = bb;
      csync_n = s;
      ypbpr_n = m;
      dsync_n = ds;
      @(negedge clk);
   endtask

   task automatic send3(input string tag, input logic [6:0] rr, input logic [6:0] gg,
                        input logic [6:0] bb, input logic m, input int e1, input int e2,
                        input int e3);
      repeat (3) drive(rr, gg, bb, 1'b1, m, 1'b0);
      check_px(tag, e1, e2, e3, 1);
   endtask

   initial begin
      rst_n   = 1'b0;
      dsync_n = 1'b1;
      csync_n = 1'b1;
      ypbpr_n = 1'b1;
      r = '0; g = '0; b = '0;
      repeat (3) @(negedge clk);
      check_px("reset", 0, 0, 0, 1);
      rst_n = 1'b1;

      // Colour vectors: expected (V1, V2, V3)
      send3("black_y",   7'd0,   7'd0,   7'd0,   1'b0, 64,  0,   64);
      send3("black_rgb", 7'd0,   7'd0,   7'd0,   1'b1, 0,   0,   0);
      send3("white_y",   7'd127, 7'd127, 7'd127, 1'b0, 64,  127, 64);
      send3("red_y",     7'd127, 7'd0,   7'd0,   1'b0, 127, 38,  43);
      send3("blue_y",    7'd0,   7'd0,   7'd127, 1'b0, 54,  15,  127);
      send3("green_y",   7'd0,   7'd127, 7'd0,   1'b0, 11,  75,  22);
      send3("red_rgb",   7'd127, 7'd0,   7'd0,   1'b1, 127, 0,   0);
      send3("mix_rgb",   7'd5,   7'd99,  7'd42,  1'b1, 5,   99,  42);
      send3("white_rgb", 7'd127, 7'd127, 7'd127, 1'b1, 127, 127, 127);

      // Continuous strobe, alternating mode on red, sync low on pixel 3 only
      for (int i = 0; i < 8; i++) begin
         drive(7'd127, 7'd0, 7'd0, (i == 3) ? 1'b0 : 1'b1, 1'(i % 2), 1'b0);
         if (i >= 2) begin
            if ((i - 2) % 2 == 1) check_px($sformatf("tog%0d", i), 127, 0, 0, (i == 5) ? 0 : 1);
            else check_px($sformatf("tog%0d", i), 127, 38, 43, (i == 5) ? 0 : 1);
         end
      end

      // Strobe every 4 cycles; garbage on inputs between strobes must be ignored
      for (int k = 0; k < 6; k++) begin
         drive(7'(10 * k + 3), 7'(100 - k), 7'(7 * k), (k == 2) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         for (int c = 0; c < 4; c++) begin
            if (k >= 2)
               check_px($sformatf("gate%0d_%0d", k, c), 10 * (k - 2) + 3, 100 - (k - 2),
                        7 * (k - 2), (k == 4) ? 0 : 1);
            if (c < 3) drive(7'h55, 7'h2a, 7'h7f, 1'b0, 1'b0, 1'b1);
         end
      end

      // Reset mid-operation with a full pipeline and strobe active
      repeat (3) drive(7'd127, 7'd127, 7'd127, 1'b1, 1'b0, 1'b0);
      check_px("pre_rst", 64, 127, 64, 1);
      rst_n = 1'b0;
      drive(7'd127, 7'd127, 7'd127, 1'b0, 1'b0, 1'b0);
      check_px("in_rst", 0, 0, 0, 1);
      rst_n = 1'b1;
      drive(7'd127, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      check_px("post_rst1", 0, 0, 0, 1);
      drive(7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0);
      check_px("post_rst2", 0, 0, 0, 1);
      drive(7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0);
      check_px("post_rst3", 127, 38, 43, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
